bb_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered black-box compute unit (2 operand bits in, 1 result bit out, posedge-registered, LAT-cycle latency) among N_REQ requesters. It sits between requester logic and the single black-box instance in the top level. It grants one requester at a time, drives the shared operand bus, counts the unit latency, captures the result and returns it with a one-cycle per-requester valid pulse. Only one operation is in flight at a time; there is no pipelining across requesters.

---
 rtl/bb_share_arbiter.sv | 87 ++++++++
 tb/tb_bb_share_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bb_share_arbiter.sv
// bb_share_arbiter: round-robin sharing of one registered black-box unit among N_REQ requesters.
// Define BB_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; the round-robin pointer is then dropped.
module bb_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op_a,
  input  logic [N_REQ-1:0] op_b,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] rsp_valid,
  output logic             rsp_data,
  output logic             busy,
  output logic             bb_in1,
  output logic             bb_in2,
  input  logic             bb_out
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]    state;
  logic [IW-1:0] win, pick;
  logic [2:0]    cnt;
`ifdef BB_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[k]) pick = IW'(k);
  end
`else
  logic [IW-1:0] rr_ptr;
  // descending scan so the first set bit at or after rr_ptr wins
  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N_REQ]) pick = IW'((int'(rr_ptr) + k) % N_REQ);
  end
`endif
  // bb_in1/bb_in2 double as the captured operand registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      busy      <= 1'b0;
      bb_in1    <= 1'b0;
      bb_in2    <= 1'b0;
      win       <= '0;
      cnt       <= '0;
`ifndef BB_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req) begin
          state  <= ISSUE;
          busy   <= 1'b1;
          win    <= pick;
          gnt    <= N_REQ'(1) << pick;
          bb_in1 <= op_a[pick];
          bb_in2 <= op_b[pick];
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 3'(LAT - 1);
        end
        WAIT: if (cnt == 3'd0) begin
          state     <= RESP;
          rsp_data  <= bb_out;
          rsp_valid <= N_REQ'(1) << win;
        end else cnt <= cnt - 3'd1;
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          bb_in1 <= 1'b0;
          bb_in2 <= 1'b0;
`ifndef BB_ARB_FIXED_PRIO_EN
          rr_ptr <= (win == IW'(N_REQ - 1)) ? '0 : IW'(win + 1'b1);
`endif
        end
      endcase
    end
endmodule

// File: tb/tb_bb_share_arbiter.sv
// tb_bb_share_arbiter: vector table, corner sequences and random ops against a transaction-level model.
// Two instances: LAT=1 (main) and LAT=3 (latency check); black box modelled as a registered AND.
module tb_bb_share_arbiter;
  localparam int L1 = 1;
  localparam int L3 = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, op_a = '0, op_b = '0, gnt, rsp_valid;
  logic rsp_data, busy, bb_in1, bb_in2, bb_out;
  logic [3:0] r3 = '0, a3 = '0, b3 = '0, g3, v3;
  logic d3, busy3, i1_3, i2_3, o3;
  logic p1 = 1'b0;
  logic [2:0] p3 = '0;
  int n_tests = 0, n_fail = 0, ptr = 0;

  always #5 clk = ~clk;

  bb_share_arbiter #(.N_REQ(4), .LAT(L1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .bb_in1(bb_in1),
    .bb_in2(bb_in2), .bb_out(bb_out));

  bb_share_arbiter #(.N_REQ(4), .LAT(L3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(r3), .op_a(a3), .op_b(b3), .gnt(g3),
    .rsp_valid(v3), .rsp_data(d3), .busy(busy3), .bb_in1(i1_3),
    .bb_in2(i2_3), .bb_out(o3));

  always @(posedge clk) begin
    p1 <= bb_in1 & bb_in2;
    p3 <= {p3[1:0], i1_3 & i2_3};
  end
  assign bb_out = p1;
  assign o3 = p3[2];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);
    chk("rsp_onehot", 8'($countones(rsp_valid) <= 1), 8'd1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [3:0] r);
`ifdef BB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
    for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return 0;
  endfunction

  // one full operation starting in IDLE; ops are forced to 1 during WAIT to expose late capture
  task automatic do_op(input logic [3:0] r, a, b, input bit drop, input logic [3:0] eg, input logic ed);
    req = r; op_a = a; op_b = b;
    tick;
    chk("gnt", 8'(gnt), 8'(eg));
    chk("busy_issue", 8'(busy), 8'd1);
    chk("bb_in1", 8'(bb_in1), 8'(|(a & eg)));
    chk("bb_in2", 8'(bb_in2), 8'(|(b & eg)));
    if (drop) req = r & ~eg;
    op_a = '1; op_b = '1;
    repeat (L1) begin
      tick;
      chk("gnt_wait", 8'(gnt), 8'd0);
      chk("rsp_wait", 8'(rsp_valid), 8'd0);
      chk("bb_in1_hold", 8'(bb_in1), 8'(|(a & eg)));
    end
    tick;
    chk("rsp_valid", 8'(rsp_valid), 8'(eg));
    chk("rsp_data", 8'(rsp_data), 8'(ed));
    chk("busy_resp", 8'(busy), 8'd1);
    req = '0;
    tick;
    chk("busy_idle", 8'(busy), 8'd0);
    chk("bb_idle", 8'({bb_in1, bb_in2}), 8'd0);
    chk("rsp_idle", 8'(rsp_valid), 8'd0);
    for (int k = 0; k < 4; k++) if (eg[k]) ptr = (k + 1) % 4;
  endtask

  typedef struct {
    logic [3:0] r, a, b;
    bit drop;
    logic [3:0] eg;
    logic ed;
    logic [3:0] egf;
    logic edf;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[1] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'b0001, 1'b1};
    tbl[2] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b0001, 1'b1};
    tbl[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0001, 1'b1};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[6] = '{4'b1001, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b0001, 1'b0};
    tbl[7] = '{4'b0110, 4'b0100, 4'b0110, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0};
    tbl[8] = '{4'b0110, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0010, 1'b0};
    tbl[9] = '{4'b1011, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b0001, 1'b0};
    tick;
    tick;
    chk("rst_outs", 8'({gnt, rsp_valid}), 8'd0);
    chk("rst_misc", 8'({rsp_data, busy, bb_in1, bb_in2}), 8'd0);
    chk("rst_busy3", 8'(busy3), 8'd0);
    rst_n = 1'b1;
    tick;
    foreach (tbl[i])
`ifdef BB_ARB_FIXED_PRIO_EN
      do_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].drop, tbl[i].egf, tbl[i].edf);
`else
      do_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].drop, tbl[i].eg, tbl[i].ed);
`endif
    // move the pointer to 3, then abort an operation with reset
    do_op(4'b0100, 4'b0100, 4'b0100, 1'b0, 4'(1 << model_pick(4'b0100)), 1'b1);
    req = 4'b1000; op_a = 4'b1000; op_b = 4'b1000;
    tick;
    chk("abort_gnt", 8'(gnt), 8'(1 << model_pick(4'b1000)));
    req = '0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 8'({gnt, rsp_valid, rsp_data, busy, bb_in1, bb_in2}), 8'd0);
    rst_n = 1'b1;
    ptr = 0;
    repeat (3) begin
      tick;
      chk("no_rsp_abort", 8'({rsp_valid, busy}), 8'd0);
    end
    do_op(4'b1100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1);
    // LAT=3 instance: rsp_valid LAT+2 cycles after the sampling IDLE cycle
    r3 = 4'b0010; a3 = 4'b0010; b3 = 4'b0010;
    tick;
    chk("l3_gnt", 8'(g3), 8'b0010);
    r3 = '0; b3 = '0;
    for (int c = 0; c < L3; c++) begin
      tick;
      chk("l3_wait_busy", 8'(busy3), 8'd1);
      chk("l3_wait_rsp", 8'(v3), 8'd0);
    end
    tick;
    chk("l3_rsp", 8'(v3), 8'b0010);
    chk("l3_data", 8'(d3), 8'd1);
    chk("l3_busy_resp", 8'(busy3), 8'd1);
    tick;
    chk("l3_idle", 8'({busy3, v3}), 8'd0);
    // random operations against the model
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r, a, b;
      int w;
      r = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
      if (r == 4'd0) begin
        req = r; op_a = a; op_b = b;
        tick;
        chk("rand_idle_gnt", 8'({gnt, busy}), 8'd0);
      end else begin
        w = model_pick(r);
        do_op(r, a, b, 1'($urandom), 4'(1 << w), a[w] & b[w]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
